// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e : request-side FSM states
//   NOP_INST      : instruction presented to decode while the prefetch FIFO is empty
package fetch_pkg;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,  // no request outstanding
    FS_BUSY    = 2'd1,  // request outstanding, response will be kept
    FS_DISCARD = 2'd2   // request outstanding, response belongs to a flushed path
  } fetch_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO holding prefetched {instruction, pc} entries.
// The head entry is visible on head_o whenever empty_o is low; pop_i consumes it.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   en_i         : clock enable; low freezes all state
//   flush_i      : discard all entries (wins over push and pop)
//   push_i       : write data_i (accepted when not full, or when popping)
//   pop_i        : consume the head entry (ignored when empty)
//   head_o       : current head entry
//   count_o      : number of valid entries
//   empty_o      : no valid entries
//   full_o       : DEPTH valid entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  // A full FIFO can still accept a push in the cycle its head is popped.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_d = wr_q + PW'(1);
      if (do_pop)  rd_d = rd_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (en_i) begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge i_clk) begin
    if (en_i && do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage. Owns the fetch PC, issues single-outstanding word
// reads over a req/ack handshake, buffers returned words in a show-ahead FIFO
// and presents {inst, pc, valid} to decode. Redirects flush the FIFO and
// discard any in-flight response.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_clk_en                : global enable; low freezes all state
//   i_stall                 : decode cannot accept the head this cycle
//   i_redirect, i_redirect_pc : one-cycle restart request and target (bits [1:0] ignored)
//   o_mem_req, o_mem_addr   : read request and word-aligned address, stable until ack
//   i_mem_ack, i_mem_data   : one-cycle response strobe and read data
//   o_inst, o_pc, o_valid   : FIFO head towards decode (NOP_INST / 0 when empty)
//   o_wait                  : inverse of o_valid
module fetch #(
  parameter int            AW         = 32,
  parameter int            DW         = 32,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int            FIFO_DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clk_en,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [AW-1:0] i_redirect_pc,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_data,
  output logic [31:0]   o_inst,
  output logic [AW-1:0] o_pc,
  output logic          o_valid,
  output logic          o_wait
);

  import fetch_pkg::*;

  localparam int            CW         = $clog2(FIFO_DEPTH + 1);
  localparam int            EW         = 32 + AW;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
  localparam logic [AW-1:0] RESET_ADDR = RESET_PC & ALIGN_MASK;

  fetch_state_e  state_q;
  logic          req_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] fetch_pc_q;

  logic [EW-1:0] fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;

  logic          pop;
  logic          push;
  logic          space;
  logic [CW:0]   occupancy;
  logic [CW:0]   limit;
  logic [AW-1:0] redirect_target;
  logic [AW-1:0] addr_next;

  assign redirect_target = i_redirect_pc & ALIGN_MASK;
  assign addr_next       = addr_q + AW'(4);

  // A redirect suppresses both the pop and the push of its cycle.
  assign pop  = ~fifo_empty & ~i_stall & ~i_redirect;
  assign push = (state_q == FS_BUSY) & i_mem_ack & ~i_redirect;

  // Entries held plus the one reserved by an outstanding request must stay
  // below the depth; the pop is added to the limit side to avoid underflow.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, req_q};
  assign limit     = (CW + 1)'(FIFO_DEPTH) + {{CW{1'b0}}, pop};
  assign space     = (occupancy < limit);

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .en_i    (i_clk_en),
    .flush_i (i_redirect),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({i_mem_data[31:0], addr_q}),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Request FSM. fetch_pc_q is the next address to request; addr_q is the
  // address currently (or last) presented to memory.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FS_IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_ADDR;
      fetch_pc_q <= RESET_ADDR;
    end else if (i_clk_en) begin
      if (i_redirect) begin
        fetch_pc_q <= redirect_target;
        if (req_q && !i_mem_ack) begin
          // Keep the old request on the bus until memory answers it.
          state_q <= FS_DISCARD;
        end else begin
          state_q <= FS_BUSY;
          req_q   <= 1'b1;
          addr_q  <= redirect_target;
        end
      end else begin
        unique case (state_q)
          FS_IDLE: begin
            if (space) begin
              req_q   <= 1'b1;
              addr_q  <= fetch_pc_q;
              state_q <= FS_BUSY;
            end
          end
          FS_BUSY: begin
            if (i_mem_ack) begin
              fetch_pc_q <= addr_next;
              if (space) begin
                addr_q <= addr_next;
              end else begin
                req_q   <= 1'b0;
                state_q <= FS_IDLE;
              end
            end
          end
          FS_DISCARD: begin
            if (i_mem_ack) begin
              addr_q  <= fetch_pc_q;
              state_q <= FS_BUSY;
            end
          end
          default: begin
            req_q   <= 1'b0;
            state_q <= FS_IDLE;
          end
        endcase
      end
    end
  end

  // A response with nothing outstanding is a memory-side protocol error.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_clk_en) assert (!(i_mem_ack && !req_q));
  end

  assign o_mem_req  = req_q;
  assign o_mem_addr = addr_q;
  assign o_valid    = ~fifo_empty;
  assign o_wait     = fifo_empty;
  assign o_inst     = fifo_empty ? NOP_INST : fifo_head[EW-1:AW];
  assign o_pc       = fifo_empty ? '0 : fifo_head[AW-1:0];

endmodule

// File: tb/tb_fetch.sv
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] inst, pc;
  logic        valid, wait_o;
  int          mem_lat = 1;
  int          mem_wait = 0;

  logic        hi_req, hi_ack = 1'b0;
  logic [31:0] hi_addr, hi_data = '0, hi_inst, hi_pc;
  logic        hi_valid, hi_wait;
  logic [31:0] hi_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_acc = 0;
  logic [31:0] exp_pc = '0;
  bit          mon_en = 1'b0;

  fetch u_dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(stall),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_ack(mem_ack), .i_mem_data(mem_data),
    .o_inst(inst), .o_pc(pc), .o_valid(valid), .o_wait(wait_o)
  );

  fetch #(.RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en), .i_stall(1'b0),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_mem_req(hi_req), .o_mem_addr(hi_addr), .i_mem_ack(hi_ack), .i_mem_data(hi_data),
    .o_inst(hi_inst), .o_pc(hi_pc), .o_valid(hi_valid), .o_wait(hi_wait)
  );

  // Memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory with configurable latency: ack arrives mem_lat cycles after req is seen.
  always @(posedge clk) begin
    if (rst) begin
      mem_ack  <= 1'b0;
      mem_wait <= 0;
    end else if (clk_en) begin
      if (mem_ack) begin
        mem_ack  <= 1'b0;
        mem_wait <= 0;
      end else if (mem_req) begin
        if (mem_wait + 1 >= mem_lat) begin
          mem_ack  <= 1'b1;
          mem_data <= mem_word(mem_addr);
          mem_wait <= 0;
        end else begin
          mem_wait <= mem_wait + 1;
        end
      end
    end
  end

  // One-cycle memory for the high-reset-PC instance.
  always @(posedge clk) begin
    if (rst) hi_ack <= 1'b0;
    else if (clk_en) begin
      if (hi_ack) hi_ack <= 1'b0;
      else if (hi_req) begin
        hi_ack  <= 1'b1;
        hi_data <= mem_word(hi_addr);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) hi_q.delete();
    else if (clk_en && hi_ack) hi_q.push_back(hi_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stream model: decode must see consecutive word addresses starting at the
  // reset PC or the latest redirect target, each carrying its memory word.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (rst) exp_pc = 32'h0;
      else if (clk_en) begin
        check("mon wait", {31'b0, wait_o}, {31'b0, ~valid});
        if (valid) check("mon inst", inst, mem_word(pc));
        else begin
          check("mon empty inst", inst, NOP_INST);
          check("mon empty pc", pc, 32'h0);
        end
        if (redirect) exp_pc = redirect_pc & ~32'h3;
        else if (valid && !stall) begin
          check("mon order pc", pc, exp_pc);
          exp_pc = exp_pc + 32'h4;
          n_acc++;
        end
      end
    end
  end

  typedef struct {
    bit          first;
    bit          stall;
    bit          en;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit first, input bit st, input bit en, input bit req,
                     input logic [31:0] addr, input bit vld, input logic [31:0] p);
    vec_t v;
    v.first = first; v.stall = st; v.en = en; v.req = req;
    v.addr = addr; v.valid = vld; v.pc = p;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; redirect = 1'b0; clk_en = 1'b1; stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit          found;
    bit          seen8;
    bit          got_valid;
    bit          got_addr;
    logic [31:0] new_addr;
    logic [31:0] first_pc;

    // Zero-wait burst: cycle-by-cycle after reset release.
    add(1,0,1, 0,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h4, 1,32'h0);
    add(0,0,1, 1,32'h4, 0,32'h0);
    add(0,0,1, 1,32'h8, 1,32'h4);
    add(0,0,1, 1,32'h8, 0,32'h0);
    add(0,0,1, 1,32'hC, 1,32'h8);
    // Stall for 6 cycles: FIFO fills, req drops, head held, then resumes.
    add(1,1,1, 0,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h0, 0,32'h0);
    add(0,1,1, 1,32'h4, 1,32'h0);
    add(0,1,1, 1,32'h4, 1,32'h0);
    add(0,1,1, 0,32'h4, 1,32'h0);
    add(0,0,1, 0,32'h4, 1,32'h0);
    add(0,0,1, 1,32'h8, 1,32'h4);
    add(0,0,1, 1,32'h8, 0,32'h0);
    add(0,0,1, 1,32'hC, 1,32'h8);
    // Clock enable low for 4 cycles mid-burst: everything frozen.
    add(1,0,1, 0,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h0, 0,32'h0);
    add(0,0,1, 1,32'h4, 1,32'h0);
    add(0,0,1, 1,32'h4, 0,32'h0);
    add(0,0,0, 1,32'h8, 1,32'h4);
    add(0,0,0, 1,32'h8, 1,32'h4);
    add(0,0,0, 1,32'h8, 1,32'h4);
    add(0,0,0, 1,32'h8, 1,32'h4);
    add(0,0,1, 1,32'h8, 1,32'h4);
    add(0,0,1, 1,32'h8, 0,32'h0);
    add(0,0,1, 1,32'hC, 1,32'h8);

    mem_lat = 1;
    do_reset();
    mon_en = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].first) do_reset();
      stall  = vecs[i].stall;
      clk_en = vecs[i].en;
      @(negedge clk);
      check($sformatf("vec%0d req", i), {31'b0, mem_req}, {31'b0, vecs[i].req});
      check($sformatf("vec%0d addr", i), mem_addr, vecs[i].addr);
      check($sformatf("vec%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].valid});
      check($sformatf("vec%0d wait", i), {31'b0, wait_o}, {31'b0, ~vecs[i].valid});
      check($sformatf("vec%0d pc", i), pc, vecs[i].pc);
      check($sformatf("vec%0d inst", i), inst, vecs[i].valid ? mem_word(vecs[i].pc) : NOP_INST);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    stall  = 1'b0;

    // High reset PC wraps through the top of the address space.
    do_reset();
    repeat (12) @(posedge clk);
    check("hi ack count>=3", {31'b0, hi_q.size() >= 3}, 32'h1);
    if (hi_q.size() >= 3) begin
      check("hi addr0", hi_q[0], 32'hFFFF_FFF8);
      check("hi addr1", hi_q[1], 32'hFFFF_FFFC);
      check("hi addr2", hi_q[2], 32'h0000_0000);
    end

    // Redirect while the request at 0x8 is still waiting (3-cycle memory).
    mem_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h8) found = 1'b1;
    end
    check("t3 reached addr 8", {31'b0, found}, 32'h1);
    @(posedge clk); #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t3 discard req", {31'b0, mem_req}, 32'h1);
    check("t3 discard addr held", mem_addr, 32'h8);
    check("t3 flushed", {31'b0, valid}, 32'h0);
    seen8 = 1'b0; got_valid = 1'b0; got_addr = 1'b0;
    new_addr = '0; first_pc = '0;
    for (int i = 0; i < 40 && !got_valid; i++) begin
      @(negedge clk);
      if (valid && pc == 32'h8) seen8 = 1'b1;
      if (!got_addr && mem_req && mem_addr != 32'h8) begin
        got_addr = 1'b1;
        new_addr = mem_addr;
      end
      if (valid) begin
        got_valid = 1'b1;
        first_pc  = pc;
      end
    end
    check("t3 got valid", {31'b0, got_valid}, 32'h1);
    check("t3 next req addr", new_addr, 32'h100);
    check("t3 first pc", first_pc, 32'h100);
    check("t3 stale 0x8 shown", {31'b0, seen8}, 32'h0);

    // Redirect to an unaligned target in the same cycle as an ack.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_ack && mem_addr == 32'h4) found = 1'b1;
    end
    check("t4 reached ack at 4", {31'b0, found}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h203;
    @(posedge clk); #1;
    redirect = 1'b0;
    @(negedge clk);
    check("t4 fifo empty", {31'b0, valid}, 32'h0);
    check("t4 req", {31'b0, mem_req}, 32'h1);
    check("t4 req addr", mem_addr, 32'h200);
    got_valid = 1'b0; first_pc = '0;
    for (int i = 0; i < 40 && !got_valid; i++) begin
      @(negedge clk);
      if (valid) begin
        got_valid = 1'b1;
        first_pc  = pc;
      end
    end
    check("t4 first pc", first_pc, 32'h200);

    // Randomized traffic checked by the stream model.
    mem_lat = int'($urandom_range(1, 4));
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      stall       = ($urandom % 10) < 3;
      clk_en      = ($urandom % 10) != 0;
      redirect    = ($urandom % 40) == 0;
      redirect_pc = $urandom;
      if (($urandom % 200) == 0) mem_lat = int'($urandom_range(1, 4));
    end
    @(posedge clk); #1;
    redirect = 1'b0; stall = 1'b0; clk_en = 1'b1;
    check("rand progress", {31'b0, n_acc >= 200}, 32'h1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
